// File: rtl/rr_grant_arbiter.sv
// Registered 8-way round-robin arbiter driving the one-hot encoder DATA input.
// grant is always zero or one-hot; valid qualifies it and timeout flags hold-limit revocation.
module rr_grant_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic       valid,
    output logic       timeout
);
    // state | meaning
    // IDLE  | no grant active; next requester chosen by scanning req from ptr
    // BUSY  | grant to idx held until done, requester drop or hold limit

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [7:0]       grant_d;
    logic             valid_d;
    logic             timeout_d;
    logic [2:0]       pick;
    logic             rel_done;
    logic             rel_drop;
    logic             rel_to;

    // Walk from ptr+7 down to ptr so the lowest rotated offset wins.
    always_comb begin
        pick = ptr_q;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr_q + 3'(i)]) begin
                pick = ptr_q + 3'(i);
            end
        end
    end

    assign rel_done = done;
    assign rel_drop = ~req[idx_q];
    assign rel_to   = (MAX_HOLD != 0) && (hcnt_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hcnt_d    = hcnt_q;
        grant_d   = grant;
        valid_d   = valid;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = 8'b1 << pick;
                    idx_d   = pick;
                    valid_d = 1'b1;
                    hcnt_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                hcnt_d = hcnt_q + 1'b1;
                if (rel_done || rel_drop || rel_to) begin
                    grant_d   = 8'h00;
                    valid_d   = 1'b0;
                    ptr_d     = idx_q + 3'd1;
                    timeout_d = rel_to && !rel_done && !rel_drop;
                    state_d   = IDLE;
                end
            end
            default: begin
                grant_d = 8'h00;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            idx_q   <= 3'd0;
            hcnt_q  <= '0;
            grant   <= 8'h00;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            hcnt_q  <= hcnt_d;
            grant   <= grant_d;
            valid   <= valid_d;
            timeout <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: reference model feeds a scoreboard queue, plus directed
// checks of grant order, pointer wrap, hold timeout, requester drop and mid-grant reset.
module tb_rr_grant_arbiter;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       valid;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [7:0] g;
        logic       v;
        logic       t;
    } exp_t;

    exp_t sb[$];

    bit m_busy = 0;
    int m_ptr  = 0;
    int m_idx  = 0;
    int m_held = 0;

    rr_grant_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: m_held counts cycles the grant has already been visible.
    task automatic model_edge(output exp_t e);
        bit found;
        bit d_rel;
        bit t_rel;
        e = '0;
        if (rst) begin
            m_busy = 0;
            m_ptr  = 0;
            m_held = 0;
        end else if (!m_busy) begin
            if (req != 8'h00) begin
                found = 0;
                for (int k = 0; k < 8; k++) begin
                    if (!found && req[(m_ptr + k) % 8]) begin
                        m_idx = (m_ptr + k) % 8;
                        found = 1;
                    end
                end
                m_busy = 1;
                m_held = 1;
                e.g    = 8'(1 << m_idx);
                e.v    = 1'b1;
            end
        end else begin
            d_rel = done || !req[m_idx];
            t_rel = (MAX_HOLD != 0) && (m_held == MAX_HOLD);
            if (d_rel || t_rel) begin
                m_busy = 0;
                m_ptr  = (m_idx + 1) % 8;
                e.t    = t_rel && !d_rel;
            end else begin
                m_held++;
                e.g = 8'(1 << m_idx);
                e.v = 1'b1;
            end
        end
    endtask

    task automatic step(input string tag);
        exp_t e;
        exp_t q;
        model_edge(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        q = sb.pop_front();
        chk({tag, "_grant"}, 32'(grant), 32'(q.g));
        chk({tag, "_valid"}, 32'(valid), 32'(q.v));
        chk({tag, "_timeout"}, 32'(timeout), 32'(q.t));
        chk({tag, "_onehot"}, 32'($countones(grant) <= 1), 32'd1);
    endtask

    logic [7:0] rot_exp [17];

    initial begin
        rot_exp = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h08, 8'h00,
                    8'h10, 8'h00, 8'h20, 8'h00, 8'h40, 8'h00, 8'h80, 8'h00, 8'h01};
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        step("rst");
        step("rst");
        chk("rst_grant", 32'(grant), 32'h00);
        chk("rst_valid", 32'(valid), 32'h0);
        rst = 1'b0;

        // basic grant, 3-cycle hold, release then pointer at 1
        req = 8'h01;
        step("t1");
        chk("t1_first", 32'(grant), 32'h01);
        step("t1");
        step("t1");
        chk("t1_held", 32'(grant), 32'h01);
        done = 1'b1;
        step("t1");
        chk("t1_release", 32'(grant), 32'h00);
        done = 1'b0;
        req  = 8'h03;
        step("t1");
        chk("t1_ptr1", 32'(grant), 32'h02);
        done = 1'b1;
        step("t1");

        // rotation through all eight with done every grant cycle
        rst = 1'b1;
        step("t2");
        rst = 1'b0;
        req = 8'hFF;
        for (int i = 0; i < 17; i++) begin
            step("t2");
            chk("t2_seq", 32'(grant), 32'(rot_exp[i]));
        end
        step("t2");

        // pointer wrap after a grant to bit 6
        done = 1'b0;
        req  = 8'h40;
        step("t3");
        chk("t3_bit6", 32'(grant), 32'h40);
        done = 1'b1;
        step("t3");
        done = 1'b0;
        req  = 8'h41;
        step("t3");
        chk("t3_wrap", 32'(grant), 32'h01);
        done = 1'b1;
        step("t3");

        // hold timeout
        done = 1'b0;
        req  = 8'h10;
        for (int i = 0; i < 4; i++) begin
            step("t4");
            chk("t4_hold", 32'(grant), 32'h10);
        end
        step("t4");
        chk("t4_to_grant", 32'(grant), 32'h00);
        chk("t4_to_pulse", 32'(timeout), 32'h1);
        step("t4");
        chk("t4_regrant", 32'(grant), 32'h10);
        chk("t4_pulse_end", 32'(timeout), 32'h0);
        step("t4");
        step("t4");
        step("t4");
        done = 1'b1;
        step("t4");
        chk("t4_done_at_limit", 32'(timeout), 32'h0);
        chk("t4_done_grant", 32'(grant), 32'h00);

        // requester drop
        rst  = 1'b1;
        done = 1'b0;
        step("t5");
        rst = 1'b0;
        req = 8'h0C;
        step("t5");
        chk("t5_grant4", 32'(grant), 32'h04);
        req = 8'h08;
        step("t5");
        chk("t5_drop", 32'(grant), 32'h00);
        chk("t5_no_to", 32'(timeout), 32'h0);
        step("t5");
        chk("t5_next", 32'(grant), 32'h08);
        done = 1'b1;
        step("t5");

        // reset mid-grant
        rst  = 1'b1;
        done = 1'b0;
        step("t6");
        rst = 1'b0;
        req = 8'h08;
        step("t6");
        step("t6");
        step("t6");
        rst = 1'b1;
        step("t6");
        chk("t6_rst_grant", 32'(grant), 32'h00);
        chk("t6_rst_valid", 32'(valid), 32'h0);
        chk("t6_rst_to", 32'(timeout), 32'h0);
        rst = 1'b0;
        req = 8'h88;
        step("t6");
        chk("t6_ptr0", 32'(grant), 32'h08);
        done = 1'b1;
        step("t6");

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            req  = 8'($urandom_range(0, 255));
            done = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 63) == 0);
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
